// File: rtl/sequence_player.sv
// sequence_player
// Plays the first (round_ctr+1) colours of a packed colour sequence, one at a
// time. Each colour is lit for an ON phase, optionally followed by a dark GAP
// phase. The sequence, length and phase durations are snapshotted at start, so
// the game FSM may change its inputs while playback is running.
//
// Ports
//   clk              in   rising-edge clock
//   rst_player       in   synchronous active-high reset
//   en_player        in   start request; re-armed by any cycle with en low
//   abort_player     in   stop playback at the next edge (no complete pulse)
//   seq_in_player    in   colours packed LSB-first, colour i at [i*COLOUR_W +: COLOUR_W]
//   round_ctr        in   N => play N+1 colours (clamped to MAX_LEN)
//   speed            in   phase durations are base >> speed
//   colour_bus       out  current colour, 0 while colour_oe is low
//   colour_oe        out  high during ON phases only
//   led_onehot       out  one-hot LED drive of colour_bus, 0 while dark
//   busy_player      out  high during ON or GAP
//   pos_player       out  index of the colour being played
//   complete_player  out  one-cycle pulse after the final ON phase
module sequence_player #(
  parameter int COLOUR_W   = 2,
  parameter int MAX_LEN    = 16,
  parameter int ON_CYCLES  = 5_000_000,
  parameter int GAP_CYCLES = 1_000_000,
  localparam int NUM_COLOURS = 2 ** COLOUR_W,
  localparam int LEN_W       = $clog2(MAX_LEN)
) (
  input  logic                          clk,
  input  logic                          rst_player,
  input  logic                          en_player,
  input  logic                          abort_player,
  input  logic [MAX_LEN*COLOUR_W-1:0]   seq_in_player,
  input  logic [LEN_W-1:0]              round_ctr,
  input  logic [1:0]                    speed,
  output logic [COLOUR_W-1:0]           colour_bus,
  output logic                          colour_oe,
  output logic [NUM_COLOURS-1:0]        led_onehot,
  output logic                          busy_player,
  output logic [LEN_W-1:0]              pos_player,
  output logic                          complete_player
);

  localparam int MAX_DUR = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_DUR + 1);
  localparam logic [CNT_W-1:0] ON_BASE  = CNT_W'(ON_CYCLES);
  localparam logic [CNT_W-1:0] GAP_BASE = CNT_W'(GAP_CYCLES);
  localparam logic [LEN_W-1:0] LAST_POS = LEN_W'(MAX_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  state_t                        state_reg, state_next;
  logic                          armed_reg, armed_next;
  logic [LEN_W-1:0]              len_reg, len_next;
  logic [MAX_LEN*COLOUR_W-1:0]   seq_reg, seq_next;
  logic [CNT_W-1:0]              on_reg, on_next;
  logic [CNT_W-1:0]              gap_reg, gap_next;
  logic [CNT_W-1:0]              cnt_reg, cnt_next;
  logic [LEN_W-1:0]              pos_reg, pos_next;
  logic [COLOUR_W-1:0]           bus_reg, bus_next;
  logic                          oe_reg, oe_next;
  logic                          busy_reg, busy_next;
  logic                          complete_reg, complete_next;
  logic [NUM_COLOURS-1:0]        led_reg, led_next;

  // Snapshotted sequence viewed as an array of colours.
  logic [COLOUR_W-1:0] colour_arr [MAX_LEN];
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_colour
      assign colour_arr[gi] = seq_reg[gi*COLOUR_W +: COLOUR_W];
    end
  endgenerate

  logic [LEN_W-1:0] pos_inc;
  logic [CNT_W-1:0] on_shift;
  logic [CNT_W-1:0] on_dur;
  logic [LEN_W-1:0] len_clamp;

  assign pos_inc  = pos_reg + 1'b1;
  assign on_shift = ON_BASE >> speed;
  // A colour is always lit for at least one cycle, even at top speed.
  assign on_dur   = (on_shift == '0) ? CNT_W'(1) : on_shift;
  // Widened compare so the clamp stays meaningful for non-power-of-two MAX_LEN.
  assign len_clamp = (32'(round_ctr) > 32'(MAX_LEN - 1)) ? LAST_POS : round_ctr;

  always_comb begin
    state_next    = state_reg;
    armed_next    = armed_reg | ~en_player;
    len_next      = len_reg;
    seq_next      = seq_reg;
    on_next       = on_reg;
    gap_next      = gap_reg;
    cnt_next      = cnt_reg;
    pos_next      = pos_reg;
    bus_next      = bus_reg;
    oe_next       = oe_reg;
    busy_next     = busy_reg;
    complete_next = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (armed_reg && en_player) begin
          state_next = S_ON;
          armed_next = 1'b0;
          len_next   = len_clamp;
          seq_next   = seq_in_player;
          on_next    = on_dur;
          gap_next   = GAP_BASE >> speed;
          cnt_next   = '0;
          pos_next   = '0;
          bus_next   = seq_in_player[COLOUR_W-1:0];
          oe_next    = 1'b1;
          busy_next  = 1'b1;
        end
      end

      S_ON: begin
        if (abort_player) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          bus_next   = '0;
          oe_next    = 1'b0;
          busy_next  = 1'b0;
        end else if (cnt_reg == on_reg - 1'b1) begin
          cnt_next = '0;
          if (pos_reg == len_reg) begin
            state_next    = S_IDLE;
            bus_next      = '0;
            oe_next       = 1'b0;
            busy_next     = 1'b0;
            complete_next = 1'b1;
          end else if (gap_reg == '0) begin
            // Zero-length gap: step straight to the next colour, LED stays lit.
            pos_next = pos_inc;
            bus_next = colour_arr[pos_inc];
          end else begin
            state_next = S_GAP;
            bus_next   = '0;
            oe_next    = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_GAP: begin
        if (abort_player) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          bus_next   = '0;
          oe_next    = 1'b0;
          busy_next  = 1'b0;
        end else if (cnt_reg == gap_reg - 1'b1) begin
          state_next = S_ON;
          cnt_next   = '0;
          pos_next   = pos_inc;
          bus_next   = colour_arr[pos_inc];
          oe_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
        bus_next   = '0;
        oe_next    = 1'b0;
        busy_next  = 1'b0;
      end
    endcase

    // Derived from next-state values so the LEDs line up with colour_bus.
    led_next = oe_next ? (NUM_COLOURS'(1) << bus_next) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst_player) begin
      state_reg    <= S_IDLE;
      armed_reg    <= 1'b1;
      len_reg      <= '0;
      seq_reg      <= '0;
      on_reg       <= '0;
      gap_reg      <= '0;
      cnt_reg      <= '0;
      pos_reg      <= '0;
      bus_reg      <= '0;
      oe_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      complete_reg <= 1'b0;
      led_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      armed_reg    <= armed_next;
      len_reg      <= len_next;
      seq_reg      <= seq_next;
      on_reg       <= on_next;
      gap_reg      <= gap_next;
      cnt_reg      <= cnt_next;
      pos_reg      <= pos_next;
      bus_reg      <= bus_next;
      oe_reg       <= oe_next;
      busy_reg     <= busy_next;
      complete_reg <= complete_next;
      led_reg      <= led_next;
    end
  end

  assign colour_bus      = bus_reg;
  assign colour_oe       = oe_reg;
  assign led_onehot      = led_reg;
  assign busy_player     = busy_reg;
  assign pos_player      = pos_reg;
  assign complete_player = complete_reg;

endmodule

// File: tb/tb_sequence_player.sv
// Directed testbench for sequence_player (COLOUR_W=2, ON=4, GAP=2), with a
// MAX_LEN=8 instance for most scenarios and a MAX_LEN=4 instance alongside it
// for the full-length snapshot scenario.
module tb_sequence_player;

  logic        clk;
  logic        rst;
  logic        en;
  logic        abort;
  logic [15:0] seq;
  logic [2:0]  rc;
  logic [1:0]  speed;
  logic [1:0]  bus;
  logic        oe;
  logic [3:0]  led;
  logic        busy;
  logic [2:0]  pos;
  logic        done;

  logic        en4;
  logic [7:0]  seq4;
  logic [1:0]  rc4;
  logic [1:0]  bus4;
  logic        oe4;
  logic [3:0]  led4;
  logic        busy4;
  logic [1:0]  pos4;
  logic        done4;

  int passed;
  int total;

  sequence_player #(.COLOUR_W(2), .MAX_LEN(8), .ON_CYCLES(4), .GAP_CYCLES(2)) u_dut (
    .clk(clk), .rst_player(rst), .en_player(en), .abort_player(abort),
    .seq_in_player(seq), .round_ctr(rc), .speed(speed),
    .colour_bus(bus), .colour_oe(oe), .led_onehot(led), .busy_player(busy),
    .pos_player(pos), .complete_player(done)
  );

  sequence_player #(.COLOUR_W(2), .MAX_LEN(4), .ON_CYCLES(4), .GAP_CYCLES(2)) u_dut4 (
    .clk(clk), .rst_player(rst), .en_player(en4), .abort_player(abort),
    .seq_in_player(seq4), .round_ctr(rc4), .speed(speed),
    .colour_bus(bus4), .colour_oe(oe4), .led_onehot(led4), .busy_player(busy4),
    .pos_player(pos4), .complete_player(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (busy !== 1'b0) $display("FAIL %s timeout: busy=%b after %0d cycles, want 0", name, busy, n);
    else passed++;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; en4 = 1'b0; abort = 1'b0;
    seq = '0; rc = '0; seq4 = '0; rc4 = '0; speed = '0;
    tick();
    tick();
    total++;
    if ({bus, oe, led, busy, pos, done} !== 12'd0)
      $display("FAIL reset outputs: got {bus,oe,led,busy,pos,done}=%b want 0", {bus, oe, led, busy, pos, done});
    else passed++;
    total++;
    if ({bus4, oe4, led4, busy4, pos4, done4} !== 11'd0)
      $display("FAIL reset outputs4: got %b want 0", {bus4, oe4, led4, busy4, pos4, done4});
    else passed++;
    rst = 1'b0;
    tick();
    $display("reset: released");
  endtask

  // seq=0x39 -> colours 1,2,3; three colours with 2-cycle gaps.
  task automatic test_basic();
    logic [1:0] eb;
    logic       eo, ebusy, ed;
    logic [3:0] el;
    logic [2:0] ep;
    seq = 16'h0039; rc = 3'd2; speed = 2'd0;
    en = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) en = 1'b0;
      eo    = (c >= 1 && c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16);
      eb    = !eo ? 2'd0 : (c <= 4) ? 2'd1 : (c <= 10) ? 2'd2 : 2'd3;
      ebusy = (c >= 1 && c <= 16);
      ed    = (c == 17);
      el    = eo ? (4'b0001 << eb) : 4'b0000;
      ep    = (c <= 6) ? 3'd0 : (c <= 12) ? 3'd1 : 3'd2;
      total++;
      if ({bus, oe, busy, done, led} !== {eb, eo, ebusy, ed, el})
        $display("FAIL basic c%0d: got {bus,oe,busy,done,led}=%b want %b", c, {bus, oe, busy, done, led}, {eb, eo, ebusy, ed, el});
      else passed++;
      if (c <= 16) begin
        total++;
        if (pos !== ep) $display("FAIL basic_pos c%0d: got %0d want %0d", c, pos, ep);
        else passed++;
      end
    end
    $display("basic: playback of 3 colours finished");
  endtask

  // speed=2: ON=1 cycle, gap=0 -> colours back to back.
  task automatic test_speed();
    logic [1:0] eb;
    logic       eo, ed;
    seq = 16'h0039; rc = 3'd2; speed = 2'd2;
    en = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) en = 1'b0;
      eo = (c <= 3);
      eb = (c == 1) ? 2'd1 : (c == 2) ? 2'd2 : (c == 3) ? 2'd3 : 2'd0;
      ed = (c == 4);
      total++;
      if ({bus, oe, busy, done} !== {eb, eo, eo, ed})
        $display("FAIL speed c%0d: got {bus,oe,busy,done}=%b want %b", c, {bus, oe, busy, done}, {eb, eo, eo, ed});
      else passed++;
    end
    speed = 2'd0;
    $display("speed: fast playback finished");
  endtask

  task automatic test_abort();
    int n_done;
    n_done = 0;
    seq = 16'h0039; rc = 3'd2;
    en = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 1) en = 1'b0;
      if (done) n_done++;
      if (c == 8) begin
        total++;
        if ({bus, oe, busy} !== {2'd2, 1'b1, 1'b1})
          $display("FAIL abort_pre: got {bus,oe,busy}=%b want 10_1_1", {bus, oe, busy});
        else passed++;
        abort = 1'b1;
      end
      if (c == 9) begin
        total++;
        if ({bus, oe, busy, led} !== 8'd0)
          $display("FAIL abort_stop: got {bus,oe,busy,led}=%b want 0", {bus, oe, busy, led});
        else passed++;
        abort = 1'b0;
      end
    end
    total++;
    if (n_done !== 0) $display("FAIL abort_no_done: got %0d complete pulses want 0", n_done);
    else passed++;
    en = 1'b1;
    tick();
    total++;
    if ({bus, oe, busy} !== {2'd1, 1'b1, 1'b1})
      $display("FAIL abort_restart: got {bus,oe,busy}=%b want 01_1_1", {bus, oe, busy});
    else passed++;
    en = 1'b0;
    wait_idle("abort_restart", 100);
    $display("abort: aborted playback then restarted");
  endtask

  task automatic test_rearm();
    int n_done, n_start;
    logic prev_oe;
    n_done = 0; n_start = 0; prev_oe = 1'b0;
    seq = 16'h0039; rc = 3'd0;
    en = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done) n_done++;
      if (oe && !prev_oe) n_start++;
      prev_oe = oe;
    end
    total++;
    if (n_done !== 1) $display("FAIL rearm_once_done: got %0d want 1", n_done);
    else passed++;
    total++;
    if (n_start !== 1) $display("FAIL rearm_once_start: got %0d want 1", n_start);
    else passed++;
    en = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) $display("FAIL rearm_low: got busy=%b want 0", busy);
    else passed++;
    en = 1'b1;
    tick();
    total++;
    if ({bus, oe, busy} !== {2'd1, 1'b1, 1'b1})
      $display("FAIL rearm_restart: got {bus,oe,busy}=%b want 01_1_1", {bus, oe, busy});
    else passed++;
    en = 1'b0;
    wait_idle("rearm", 100);
    $display("rearm: single playback on held enable, restart after low cycle");
  endtask

  // Full-length playback on both builds; inputs change after start.
  task automatic test_clamp_snapshot();
    logic [1:0] got8 [8];
    logic [1:0] got4 [4];
    int n8, n4, d8, d4;
    logic p8, p4;
    logic [1:0] want;
    n8 = 0; n4 = 0; d8 = 0; d4 = 0; p8 = 1'b0; p4 = 1'b0;
    seq = 16'hE4E4; rc = 3'd7;
    seq4 = 8'hE4; rc4 = 2'd3;
    en = 1'b1; en4 = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (c == 1) begin
        en = 1'b0; en4 = 1'b0;
        seq = 16'h1B1B; seq4 = 8'h1B; rc = 3'd0; rc4 = 2'd0;
      end
      if (oe && !p8) begin
        if (n8 < 8) got8[n8] = bus;
        n8++;
      end
      if (oe4 && !p4) begin
        if (n4 < 4) got4[n4] = bus4;
        n4++;
      end
      p8 = oe; p4 = oe4;
      if (done) d8++;
      if (done4) d4++;
    end
    total++;
    if (n8 !== 8 || d8 !== 1) $display("FAIL clamp_len8: got %0d colours %0d done want 8 and 1", n8, d8);
    else passed++;
    total++;
    if (n4 !== 4 || d4 !== 1) $display("FAIL clamp_len4: got %0d colours %0d done want 4 and 1", n4, d4);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      want = 2'(i % 4);
      if (i < n8) begin
        total++;
        if (got8[i] !== want) $display("FAIL snapshot8[%0d]: got %0d want %0d", i, got8[i], want);
        else passed++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      want = 2'(i);
      if (i < n4) begin
        total++;
        if (got4[i] !== want) $display("FAIL snapshot4[%0d]: got %0d want %0d", i, got4[i], want);
        else passed++;
      end
    end
    $display("clamp: max8 played %0d colours, max4 played %0d colours", n8, n4);
  endtask

  task automatic test_reset_in_gap();
    seq = 16'h0039; rc = 3'd2;
    en = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    total++;
    if ({oe, busy} !== 2'b01) $display("FAIL rst_gap_pre: got {oe,busy}=%b want 01", {oe, busy});
    else passed++;
    rst = 1'b1;
    tick();
    total++;
    if ({bus, oe, led, busy, pos, done} !== 12'd0)
      $display("FAIL rst_gap: got {bus,oe,led,busy,pos,done}=%b want 0", {bus, oe, led, busy, pos, done});
    else passed++;
    rst = 1'b0;
    tick();
    total++;
    if ({bus, oe, busy, pos} !== {2'd1, 1'b1, 1'b1, 3'd0})
      $display("FAIL rst_restart: got {bus,oe,busy,pos}=%b want 01_1_1_000", {bus, oe, busy, pos});
    else passed++;
    en = 1'b0;
    wait_idle("rst_restart", 100);
    $display("reset_in_gap: reset mid-gap then restarted");
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_basic();
    test_speed();
    test_abort();
    test_rearm();
    test_clamp_snapshot();
    test_reset_in_gap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
